// File: rtl/io_port_master_pkg.sv
// Shared types and constants for the I/O port master: FSM state encoding,
// idle enable pattern and the map of which ports are output latches.
package io_port_master_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    ENABLE = 3'd3,
    SAMPLE = 3'd4,
    DONE   = 3'd5
  } state_e;

  // Write ports idle low (strobes), read ports idle high (active-low OEs).
  localparam logic [7:0] IO_ENA_IDLE     = 8'h7C;
  localparam logic [7:0] WRITE_PORT_MASK = 8'h83;

  function automatic logic is_write_port(input logic [2:0] port);
    return WRITE_PORT_MASK[port];
  endfunction

endpackage

// File: rtl/io_port_master_if.sv
// Request/response handshake plus the I/O-side enable/data buses of the port master.
interface io_port_master_if;

  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [2:0] req_port;
  logic [7:0] req_wdata;

  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;

  logic [7:0] io_ena;
  logic [7:0] io_wdata;
  logic [7:0] io_2;
  logic [7:0] io_3;
  logic [7:0] io_4;
  logic [7:0] io_5;
  logic [7:0] io_6;

  modport master (
    input  req_valid, req_we, req_port, req_wdata,
    input  io_2, io_3, io_4, io_5, io_6,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output io_ena, io_wdata
  );

  modport slave (
    output req_valid, req_we, req_port, req_wdata,
    output io_2, io_3, io_4, io_5, io_6,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  io_ena, io_wdata
  );

endinterface

// File: rtl/io_port_master_decode.sv
// Combinational port decode: legality of the access direction for a port and
// the one-hot bit selecting that port's enable line.
module io_port_decode
  import io_port_master_pkg::*;
(
  input  logic [2:0] port,
  input  logic       we,
  output logic       legal,
  output logic [7:0] ena_onehot
);

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_onehot
      assign ena_onehot[gi] = (port == 3'(gi));
    end
  endgenerate

  // Output latches accept only writes, input buffers only reads.
  assign legal = we ? is_write_port(port) : ~is_write_port(port);

endmodule

// File: rtl/io_port_master.sv
// Sequences single I/O accesses onto eight legacy ports: write strobes,
// read output-enables with sampling, and single-cycle error completion.
module io_port_master
  import io_port_master_pkg::*;
(
  input  logic             Clock,
  input  logic             Reset,
  io_port_master_if.master bus
);

  localparam logic [2:0] ST_IDLE   = 3'(IDLE);
  localparam logic [2:0] ST_SETUP  = 3'(SETUP);
  localparam logic [2:0] ST_STROBE = 3'(STROBE);
  localparam logic [2:0] ST_ENABLE = 3'(ENABLE);
  localparam logic [2:0] ST_SAMPLE = 3'(SAMPLE);
  localparam logic [2:0] ST_DONE   = 3'(DONE);

  logic [2:0] state_reg, state_next;
  logic [2:0] port_reg;
  logic       we_reg;
  logic [7:0] io_ena_reg, io_ena_next;
  logic [7:0] io_wdata_reg;
  logic       rsp_valid_reg;
  logic       rsp_err_reg;
  logic [7:0] rsp_rdata_reg;

  logic       in_idle;
  logic       accept;
  logic [2:0] dec_port;
  logic       dec_we;
  logic       dec_legal;
  logic [7:0] dec_onehot;
  logic [7:0] read_mux;

  assign in_idle = (state_reg == ST_IDLE);
  assign accept  = in_idle && bus.req_valid;

  // In IDLE the decoder looks at the live request so the first cycle of the
  // access can already drive its enable; afterwards it uses the latched copy.
  assign dec_port = in_idle ? bus.req_port : port_reg;
  assign dec_we   = in_idle ? bus.req_we   : we_reg;

  io_port_decode u_decode (
    .port       (dec_port),
    .we         (dec_we),
    .legal      (dec_legal),
    .ena_onehot (dec_onehot)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (!dec_legal)
            state_next = ST_DONE;
          else if (bus.req_we)
            state_next = ST_SETUP;
          else
            state_next = ST_ENABLE;
        end
      end
      ST_SETUP:  state_next = ST_STROBE;
      ST_STROBE: state_next = ST_DONE;
      ST_ENABLE: state_next = ST_SAMPLE;
      ST_SAMPLE: state_next = ST_DONE;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Enables are registered from the next state so the port lines never glitch.
  always_comb begin
    io_ena_next = IO_ENA_IDLE;
    if (state_next == ST_STROBE)
      io_ena_next = IO_ENA_IDLE | dec_onehot;
    else if ((state_next == ST_ENABLE) || (state_next == ST_SAMPLE))
      io_ena_next = IO_ENA_IDLE & ~dec_onehot;
  end

  always_comb begin
    read_mux = 8'h00;
    case (port_reg)
      3'd2:    read_mux = bus.io_2;
      3'd3:    read_mux = bus.io_3;
      3'd4:    read_mux = bus.io_4;
      3'd5:    read_mux = bus.io_5;
      3'd6:    read_mux = bus.io_6;
      default: read_mux = 8'h00;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg     <= ST_IDLE;
      port_reg      <= 3'd0;
      we_reg        <= 1'b0;
      io_ena_reg    <= IO_ENA_IDLE;
      io_wdata_reg  <= 8'h00;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_rdata_reg <= 8'h00;
    end else begin
      state_reg  <= state_next;
      io_ena_reg <= io_ena_next;

      if (accept) begin
        port_reg <= bus.req_port;
        we_reg   <= bus.req_we;
        if (bus.req_we && dec_legal)
          io_wdata_reg <= bus.req_wdata;
      end

      rsp_valid_reg <= (state_next == ST_DONE);
      // Only an illegal access goes straight from IDLE to DONE.
      rsp_err_reg   <= (state_next == ST_DONE) && in_idle;

      if (state_next == ST_DONE)
        rsp_rdata_reg <= (state_reg == ST_SAMPLE) ? read_mux : 8'h00;
    end
  end

  assign bus.req_ready = in_idle;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_err   = rsp_err_reg;
  assign bus.rsp_rdata = rsp_rdata_reg;
  assign bus.io_ena    = io_ena_reg;
  assign bus.io_wdata  = io_wdata_reg;

endmodule

// File: tb/tb_io_port_master.sv
// Self-checking bench for io_port_master: per-cycle comparison against a
// schedule-based model plus hand-computed literal expectations.
module tb_io_port_master;

  logic Clock = 1'b0;
  logic Reset;

  always #5 Clock = ~Clock;

  io_port_master_if bif ();

  io_port_master dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bif)
  );

  logic [7:0] io_val [2:6];
  assign bif.io_2 = io_val[2];
  assign bif.io_3 = io_val[3];
  assign bif.io_4 = io_val[4];
  assign bif.io_5 = io_val[5];
  assign bif.io_6 = io_val[6];

  typedef struct packed {
    logic [7:0] ena;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       valid;
    logic       err;
    logic       ready;
  } exp_t;

  exp_t       exp_q [$];
  exp_t       cur;
  logic [7:0] m_wdata;
  logic [7:0] m_rdata;
  bit         model_on = 1'b0;
  int         acc_cnt  = 0;
  int         errors   = 0;
  int         checks   = 0;

  function automatic exp_t mk(input logic [7:0] ena, input logic [7:0] wdata,
                              input logic [7:0] rdata, input logic valid,
                              input logic err, input logic ready);
    exp_t e;
    e.ena = ena; e.wdata = wdata; e.rdata = rdata;
    e.valid = valid; e.err = err; e.ready = ready;
    return e;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle expectations of one access, from the port map rules.
  task automatic schedule(input logic we, input logic [2:0] p, input logic [7:0] d);
    bit         wr_port;
    logic [7:0] sel;
    wr_port = (p == 3'd0) || (p == 3'd1) || (p == 3'd7);
    sel     = 8'h01 << p;
    if (we != wr_port) begin
      exp_q.push_back(mk(8'h7C, m_wdata, 8'h00, 1'b1, 1'b1, 1'b0));
      m_rdata = 8'h00;
    end else if (we) begin
      m_wdata = d;
      exp_q.push_back(mk(8'h7C,       d, m_rdata, 1'b0, 1'b0, 1'b0));
      exp_q.push_back(mk(8'h7C | sel, d, m_rdata, 1'b0, 1'b0, 1'b0));
      exp_q.push_back(mk(8'h7C,       d, 8'h00,   1'b1, 1'b0, 1'b0));
      m_rdata = 8'h00;
    end else begin
      exp_q.push_back(mk(8'h7C & ~sel, m_wdata, m_rdata,   1'b0, 1'b0, 1'b0));
      exp_q.push_back(mk(8'h7C & ~sel, m_wdata, m_rdata,   1'b0, 1'b0, 1'b0));
      exp_q.push_back(mk(8'h7C,        m_wdata, io_val[p], 1'b1, 1'b0, 1'b0));
      m_rdata = io_val[p];
    end
  endtask

  always @(posedge Clock) begin
    if (Reset) begin
      exp_q.delete();
      m_wdata  = 8'h00;
      m_rdata  = 8'h00;
      cur      = mk(8'h7C, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
      model_on = 1'b1;
    end else if (model_on) begin
      if (exp_q.size() == 0 && cur.ready && bif.req_valid) begin
        schedule(bif.req_we, bif.req_port, bif.req_wdata);
        acc_cnt++;
      end
      if (exp_q.size() > 0)
        cur = exp_q.pop_front();
      else
        cur = mk(8'h7C, m_wdata, m_rdata, 1'b0, 1'b0, 1'b1);
    end
  end

  always @(negedge Clock) begin
    if (model_on) begin
      chk("io_ena",    bif.io_ena,    cur.ena);
      chk("io_wdata",  bif.io_wdata,  cur.wdata);
      chk("rsp_valid", 8'(bif.rsp_valid), 8'(cur.valid));
      chk("req_ready", 8'(bif.req_ready), 8'(cur.ready));
      chk("ena_one_active", 8'($countones(bif.io_ena ^ 8'h7C) <= 1), 8'd1);
      if (cur.valid) begin
        chk("rsp_err",   8'(bif.rsp_err), 8'(cur.err));
        chk("rsp_rdata", bif.rsp_rdata,   cur.rdata);
      end
    end
  end

  // Raise a request in an IDLE-aligned slot and return just after it is accepted;
  // fields are then scrambled to show that non-IDLE changes are ignored.
  task automatic issue(input logic we, input logic [2:0] p, input logic [7:0] d);
    int start;
    int n;
    start = acc_cnt;
    @(posedge Clock); #1;
    bif.req_valid = 1'b1; bif.req_we = we; bif.req_port = p; bif.req_wdata = d;
    n = 0;
    while (acc_cnt == start && n < 20) begin
      @(posedge Clock); #1;
      n++;
    end
    if (acc_cnt == start) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got none expected acceptance at %0t", $time);
    end
    bif.req_valid = 1'b0; bif.req_we = ~we; bif.req_port = ~p; bif.req_wdata = ~d;
  endtask

  typedef struct packed { logic we; logic [2:0] port; logic [7:0] data; } vec_t;
  vec_t vecs [8];

  initial begin
    int start;
    int n;
    io_val[2] = 8'h12; io_val[3] = 8'h9A; io_val[4] = 8'h3C;
    io_val[5] = 8'h5B; io_val[6] = 8'hF0;
    vecs[0] = '{1'b0, 3'd0, 8'h00};
    vecs[1] = '{1'b1, 3'd7, 8'hC3};
    vecs[2] = '{1'b0, 3'd2, 8'h00};
    vecs[3] = '{1'b0, 3'd5, 8'h00};
    vecs[4] = '{1'b1, 3'd0, 8'h0F};
    vecs[5] = '{1'b0, 3'd7, 8'h00};
    vecs[6] = '{1'b0, 3'd3, 8'h00};
    vecs[7] = '{1'b1, 3'd6, 8'hEE};

    Reset = 1'b1;
    bif.req_valid = 1'b0; bif.req_we = 1'b0; bif.req_port = 3'd0; bif.req_wdata = 8'h00;
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b0;

    @(negedge Clock);
    chk("rst_ready", 8'(bif.req_ready), 8'd1);
    chk("rst_ena",   bif.io_ena,   8'h7C);
    chk("rst_wdata", bif.io_wdata, 8'h00);
    chk("rst_rdata", bif.rsp_rdata, 8'h00);

    issue(1'b1, 3'd1, 8'hA5);
    @(negedge Clock);
    chk("wr1_setup_wdata", bif.io_wdata, 8'hA5);
    chk("wr1_setup_ena",   bif.io_ena,   8'h7C);
    @(negedge Clock);
    chk("wr1_strobe_ena",  bif.io_ena,   8'h7E);
    @(negedge Clock);
    chk("wr1_done_valid",  8'(bif.rsp_valid), 8'd1);
    chk("wr1_done_err",    8'(bif.rsp_err),   8'd0);
    @(negedge Clock);
    chk("wr1_after_ena",   bif.io_ena, 8'h7C);
    chk("wr1_after_valid", 8'(bif.rsp_valid), 8'd0);

    issue(1'b0, 3'd4, 8'h00);
    @(negedge Clock);
    chk("rd4_enable_ena", bif.io_ena, 8'h6C);
    @(negedge Clock);
    chk("rd4_sample_ena", bif.io_ena, 8'h6C);
    @(negedge Clock);
    chk("rd4_valid", 8'(bif.rsp_valid), 8'd1);
    chk("rd4_rdata", bif.rsp_rdata, 8'h3C);

    issue(1'b1, 3'd3, 8'h55);
    @(negedge Clock);
    chk("wr3_valid", 8'(bif.rsp_valid), 8'd1);
    chk("wr3_err",   8'(bif.rsp_err),   8'd1);
    chk("wr3_ena",   bif.io_ena,   8'h7C);
    chk("wr3_wdata", bif.io_wdata, 8'hA5);

    foreach (vecs[i]) issue(vecs[i].we, vecs[i].port, vecs[i].data);
    repeat (4) @(negedge Clock);

    // Back-to-back: valid held across two accesses, fields change mid-access.
    start = acc_cnt;
    @(posedge Clock); #1;
    bif.req_valid = 1'b1; bif.req_we = 1'b1; bif.req_port = 3'd0; bif.req_wdata = 8'h11;
    n = 0;
    while (acc_cnt == start && n < 20) begin @(posedge Clock); #1; n++; end
    chk("b2b_first_accept", 8'(acc_cnt - start), 8'd1);
    bif.req_we = 1'b0; bif.req_port = 3'd6; bif.req_wdata = 8'h00;
    start = acc_cnt;
    n = 0;
    while (acc_cnt == start && n < 20) begin @(posedge Clock); #1; n++; end
    chk("b2b_gap_edges", 8'(n), 8'd4);
    bif.req_valid = 1'b0;
    @(negedge Clock);
    chk("b2b_rd6_ena", bif.io_ena, 8'h3C);
    chk("b2b_wdata",   bif.io_wdata, 8'h11);
    @(negedge Clock);
    @(negedge Clock);
    chk("b2b_rd6_valid", 8'(bif.rsp_valid), 8'd1);
    chk("b2b_rd6_rdata", bif.rsp_rdata, 8'hF0);
    repeat (2) @(negedge Clock);

    // Reset during the strobe of a write to port 7.
    issue(1'b1, 3'd7, 8'h77);
    @(posedge Clock); #1;
    Reset = 1'b1;
    @(negedge Clock);
    chk("rst7_strobe_ena", bif.io_ena, 8'hFC);
    @(posedge Clock); #1;
    Reset = 1'b0;
    @(negedge Clock);
    chk("rst7_ena",   bif.io_ena, 8'h7C);
    chk("rst7_valid", 8'(bif.rsp_valid), 8'd0);
    chk("rst7_ready", 8'(bif.req_ready), 8'd1);
    @(negedge Clock);
    chk("rst7_no_rsp", 8'(bif.rsp_valid), 8'd0);

    issue(1'b0, 3'd2, 8'h00);
    repeat (4) @(negedge Clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
